// File: rtl/enc_dec_pipe.sv
// Pipelined priority encoder / one-hot decoder with valid/ready on both sides
// and bubble-collapsing stages. Define ENC_DEC_MULTI_HOT_EN to flag multi-hot encode operands.
module enc_dec_pipe #(
  parameter int unsigned N      = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_none,
  output logic         out_multi,
  output logic [15:0]  txn_count
);

  localparam int unsigned W    = $clog2(N);
  localparam int unsigned LAST = STAGES - 1;

  typedef struct packed {
    logic [N-1:0] data;
    logic         none;
    logic         multi;
  } payload_t;

  payload_t     res;
  logic [W-1:0] enc_idx;
  logic [N-1:0] shifted;

  always_comb begin
    res     = '0;
    enc_idx = '0;
    shifted = '0;
    if (!in_op) begin
      // Later (higher) set bits overwrite earlier ones, leaving the highest index.
      for (int unsigned i = 0; i < N; i++) begin
        shifted = in_data >> i;
        if (shifted[0]) enc_idx = W'(i);
      end
      res.data[W-1:0] = enc_idx;
      res.none        = ~|in_data;
`ifdef ENC_DEC_MULTI_HOT_EN
      res.multi       = |(in_data & (in_data - N'(1)));
`endif
    end else begin
      res.data = N'(1) << in_data[W-1:0];
      res.none = (32'(in_data[W-1:0]) >= N);
      if (res.none) res.data = '0;
    end
  end

  logic [STAGES-1:0] v_q, v_d, adv, load, v_src;
  logic [15:0]       txn_count_q, txn_count_d;
  payload_t [STAGES-1:0] chain;

  // A stage is stuck only when it and every later stage are full and the
  // consumer stalls: the recursive advance rule, unrolled per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    if (k == LAST) begin : g_last
      assign adv[k] = v_q[k] & out_ready;
    end else begin : g_mid
      assign adv[k] = v_q[k] & (out_ready | ~&v_q[LAST:k+1]);
    end
  end

  always_comb begin
    v_src       = v_q << 1;
    v_src[0]    = in_valid;
    load        = ~v_q | adv;
    v_d         = (load & v_src) | (~load & v_q);
    txn_count_d = txn_count_q + {15'd0, v_q[LAST] & out_ready};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '0;
      txn_count_q <= '0;
    end else begin
      v_q         <= v_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign chain[0] = res;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    payload_t pl_q, pl_d;

    always_comb begin
      pl_d = pl_q;
      if (load[k] && v_src[k]) pl_d = chain[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pl_q <= '0;
      else        pl_q <= pl_d;
    end

    if (k == LAST) begin : g_out
      assign out_data  = pl_q.data;
      assign out_none  = pl_q.none;
      assign out_multi = pl_q.multi;
    end else begin : g_fwd
      assign chain[k+1] = pl_q;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[LAST];
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_enc_dec_pipe.sv
// Self-checking bench for enc_dec_pipe: directed cases, backpressure, random
// traffic against a behavioural model, a non-power-of-two instance and async reset.
module tb_enc_dec_pipe;

  localparam int unsigned N   = 8;
  localparam int unsigned ST  = 2;
  localparam int unsigned N6  = 6;
  localparam int unsigned ST6 = 3;
`ifdef ENC_DEC_MULTI_HOT_EN
  localparam logic MH = 1'b1;
`else
  localparam logic MH = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_op, out_valid, out_ready, out_none, out_multi;
  logic [7:0]  in_data, out_data;
  logic [15:0] txn_count;

  logic        b_in_valid, b_in_ready, b_in_op, b_out_valid, b_out_ready, b_out_none, b_out_multi;
  logic [5:0]  b_in_data, b_out_data;
  logic [15:0] b_txn_count;

  enc_dec_pipe #(.N(N), .STAGES(ST)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_none(out_none), .out_multi(out_multi), .txn_count(txn_count)
  );

  enc_dec_pipe #(.N(N6), .STAGES(ST6)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_none(b_out_none), .out_multi(b_out_multi), .txn_count(b_txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       none;
    logic       multi;
  } exp_t;

  typedef struct packed {
    logic       op;
    logic [7:0] d;
    logic [7:0] xd;
    logic       xn;
    logic       xm;
  } dir_t;

  exp_t sb[$];
  int   n_vec, n_err, exp_txn;
  logic s_in_hs, s_out_hs, s_out_valid, s_in_ready;
  exp_t s_out;

  // Highest set bit of x is $clog2(x+1)-1; decode keeps only the low W index bits.
  function automatic exp_t model(input int unsigned n, input logic op, input logic [7:0] d);
    exp_t        e;
    int unsigned w, x, idx;
    e = '0;
    w = $clog2(n);
    x = 32'(d);
    if (!op) begin
      if (x == 0) e.none = 1'b1;
      else begin
        e.data  = 8'($clog2(x + 1) - 1);
        e.multi = MH && ($countones(x) > 1);
      end
    end else begin
      idx = x % (32'd1 << w);
      if (idx >= n) e.none = 1'b1;
      else          e.data = 8'(32'd1 << idx);
    end
    return e;
  endfunction

  task automatic step(input logic v, input logic op, input logic [7:0] d, input logic ordy);
    in_valid  = v;
    in_op     = op;
    in_data   = d;
    out_ready = ordy;
    #1;
    s_in_hs     = in_valid & in_ready;
    s_out_hs    = out_valid & out_ready;
    s_out_valid = out_valid;
    s_in_ready  = in_ready;
    s_out       = {out_data, out_none, out_multi};
    if (s_in_hs)  sb.push_back(model(N, op, d));
    if (s_out_hs) exp_txn++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #10;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    n_vec++; if (out_none !== 1'b0) begin n_err++; $display("FAIL reset_out_none: got %b expected 0", out_none); end
    n_vec++; if (out_multi !== 1'b0) begin n_err++; $display("FAIL reset_out_multi: got %b expected 0", out_multi); end
    n_vec++; if (txn_count !== 16'd0) begin n_err++; $display("FAIL reset_txn: got %0d expected 0", txn_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_out_valid: got %b expected 0", b_out_valid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    dir_t tbl [9];
    int   lat;
    logic seen;
    tbl[0] = '{1'b0, 8'h40, 8'd6,  1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 8'd0,  1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'hFF, 8'd7,  1'b0, MH};
    tbl[3] = '{1'b0, 8'hA0, 8'd7,  1'b0, MH};
    tbl[4] = '{1'b0, 8'h01, 8'd0,  1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h03, 8'h08, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'h07, 8'h80, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'h00, 8'h01, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 8'hF9, 8'h02, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      step(1'b1, tbl[i].op, tbl[i].d, 1'b1);
      n_vec++; if (s_in_hs !== 1'b1) begin n_err++; $display("FAIL dir_accept[%0d]: got %b expected 1", i, s_in_hs); end
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 10) begin
        step(1'b0, 1'b0, 8'($urandom), 1'b1);
        lat++;
        seen = s_out_valid;
      end
      n_vec++; if (!seen || lat != ST) begin n_err++; $display("FAIL dir_latency[%0d]: got %0d cycles expected %0d", i, lat, ST); end
      n_vec++;
      if (s_out !== {tbl[i].xd, tbl[i].xn, tbl[i].xm}) begin
        n_err++;
        $display("FAIL dir_result[%0d]: got data=%h none=%b multi=%b expected data=%h none=%b multi=%b",
                 i, s_out.data, s_out.none, s_out.multi, tbl[i].xd, tbl[i].xn, tbl[i].xm);
      end
      n_vec++; if (txn_count !== 16'(i + 1)) begin n_err++; $display("FAIL dir_txn[%0d]: got %0d expected %0d", i, txn_count, i + 1); end
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  req [4];
    int          ri, accepts;
    logic [15:0] txn0;
    exp_t        e;
    for (int j = 0; j < 4; j++) req[j] = 8'($urandom_range(1, 255));
    ri = 0;
    accepts = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b0, req[ri], 1'b0);
      if (s_in_hs) begin ri++; accepts++; end
      if (c >= 2 && sb.size() > 0) begin
        n_vec++;
        if (s_out_valid !== 1'b1 || s_out !== sb[0]) begin
          n_err++;
          $display("FAIL b2b_hold[%0d]: got valid=%b data=%h expected valid=1 data=%h", c, s_out_valid, s_out.data, sb[0].data);
        end
      end
    end
    n_vec++; if (accepts != 2) begin n_err++; $display("FAIL b2b_accepts: got %0d expected 2", accepts); end
    n_vec++; if (s_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready: got %b expected 0", s_in_ready); end
    txn0 = txn_count;
    for (int c = 0; c < 4; c++) begin
      if (ri < 4) step(1'b1, 1'b0, req[ri], 1'b1);
      else        step(1'b0, 1'b0, 8'h00, 1'b1);
      if (s_in_hs) ri++;
      n_vec++;
      if (s_out_hs !== 1'b1 || sb.size() == 0) begin
        n_err++;
        $display("FAIL b2b_rate[%0d]: got out_hs=%b expected 1", c, s_out_hs);
      end else begin
        e = sb.pop_front();
        if (s_out !== e) begin
          n_err++;
          $display("FAIL b2b_order[%0d]: got data=%h none=%b expected data=%h none=%b", c, s_out.data, s_out.none, e.data, e.none);
        end
      end
    end
    n_vec++; if (16'(txn_count - txn0) !== 16'd4) begin n_err++; $display("FAIL b2b_txn: got %0d expected 4", 16'(txn_count - txn0)); end
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL b2b_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_random();
    logic       v, op, ordy, prev_hold;
    logic [7:0] d;
    exp_t       prev_out, e;
    int         guard;
    prev_hold = 1'b0;
    prev_out  = '0;
    for (int c = 0; c < 400; c++) begin
      v    = ($urandom % 10) < 7;
      op   = 1'($urandom);
      ordy = ($urandom % 10) < 7;
      case ($urandom % 4)
        0:       d = 8'h00;
        1:       d = 8'(32'd1 << $urandom_range(0, 7));
        default: d = 8'($urandom);
      endcase
      step(v, op, d, ordy);
      if (prev_hold) begin
        n_vec++;
        if (s_out_valid !== 1'b1 || s_out !== prev_out) begin
          n_err++;
          $display("FAIL rnd_stable[%0d]: got valid=%b data=%h expected valid=1 data=%h", c, s_out_valid, s_out.data, prev_out.data);
        end
      end
      if (s_out_hs) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL rnd_extra[%0d]: got unexpected result %h expected none", c, s_out.data);
        end else begin
          e = sb.pop_front();
          if (s_out !== e) begin
            n_err++;
            $display("FAIL rnd_result[%0d]: got data=%h none=%b multi=%b expected data=%h none=%b multi=%b",
                     c, s_out.data, s_out.none, s_out.multi, e.data, e.none, e.multi);
          end
        end
      end
      n_vec++; if (sb.size() > ST) begin n_err++; $display("FAIL rnd_occupancy[%0d]: got %0d expected <= %0d", c, sb.size(), ST); end
      prev_hold = s_out_valid & ~ordy;
      prev_out  = s_out;
    end
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      guard++;
      if (s_out_hs) begin
        e = sb.pop_front();
        n_vec++;
        if (s_out !== e) begin
          n_err++;
          $display("FAIL rnd_drain: got data=%h none=%b expected data=%h none=%b", s_out.data, s_out.none, e.data, e.none);
        end
      end
    end
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL rnd_timeout: got %0d pending expected 0", sb.size()); end
    n_vec++; if (txn_count !== 16'(exp_txn)) begin n_err++; $display("FAIL rnd_txn: got %0d expected %0d", txn_count, 16'(exp_txn)); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_idle: got %b expected 0", out_valid); end
  endtask

  task automatic test_decode_n6();
    logic       ops [10];
    logic [5:0] ds  [10];
    exp_t       e;
    int         lat;
    for (int i = 0; i < 8; i++) begin
      ops[i] = 1'b1;
      ds[i]  = {3'($urandom), 3'(i)};
    end
    ops[8] = 1'b0; ds[8] = 6'b100100;
    ops[9] = 1'b0; ds[9] = 6'b000000;
    for (int i = 0; i < 10; i++) begin
      b_in_valid  = 1'b1;
      b_in_op     = ops[i];
      b_in_data   = ds[i];
      b_out_ready = 1'b1;
      #1;
      n_vec++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL n6_accept[%0d]: got %b expected 1", i, b_in_ready); end
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      b_in_data  = 6'($urandom);
      lat = 0;
      while (b_out_valid !== 1'b1 && lat < 12) begin
        @(posedge clk);
        #1;
        lat++;
      end
      e = model(N6, ops[i], {2'b00, ds[i]});
      n_vec++; if (lat != ST6 - 1) begin n_err++; $display("FAIL n6_latency[%0d]: got %0d edges expected %0d", i, lat, ST6 - 1); end
      n_vec++;
      if ({2'b00, b_out_data} !== e.data || b_out_none !== e.none || b_out_multi !== e.multi) begin
        n_err++;
        $display("FAIL n6_result[%0d]: got data=%h none=%b multi=%b expected data=%h none=%b multi=%b",
                 i, b_out_data, b_out_none, b_out_multi, e.data, e.none, e.multi);
      end
      @(posedge clk);
      #1;
    end
    n_vec++; if (b_txn_count !== 16'd10) begin n_err++; $display("FAIL n6_txn: got %0d expected 10", b_txn_count); end
  endtask

  task automatic test_async_reset();
    int   lat;
    logic seen;
    step(1'b1, 1'b0, 8'h80, 1'b0);
    step(1'b1, 1'b0, 8'h81, 1'b0);
    n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL ar_full: got valid=%b ready=%b expected 1 0", out_valid, in_ready); end
    n_vec++; if (txn_count !== 16'(exp_txn)) begin n_err++; $display("FAIL ar_pre_txn: got %0d expected %0d", txn_count, 16'(exp_txn)); end
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (txn_count !== 16'd0) begin n_err++; $display("FAIL ar_txn: got %0d expected 0", txn_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL ar_out_data: got %h expected 00", out_data); end
    sb.delete();
    exp_txn = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_vec++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL ar_ghost[%0d]: got %b expected 0", c, s_out_valid); end
    end
    step(1'b1, 1'b0, 8'h08, 1'b1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      lat++;
      seen = s_out_valid;
    end
    n_vec++; if (!seen || lat != ST) begin n_err++; $display("FAIL ar_latency: got %0d cycles expected %0d", lat, ST); end
    n_vec++; if (s_out.data !== 8'd3 || s_out.none !== 1'b0) begin n_err++; $display("FAIL ar_first: got data=%h none=%b expected 03 0", s_out.data, s_out.none); end
    n_vec++; if (txn_count !== 16'd1) begin n_err++; $display("FAIL ar_post_txn: got %0d expected 1", txn_count); end
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec       = 0;
    n_err       = 0;
    exp_txn     = 0;
    rst_n       = 1'b1;
    in_valid    = 1'b0;
    in_op       = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b1;
    b_in_valid  = 1'b0;
    b_in_op     = 1'b0;
    b_in_data   = 6'h00;
    b_out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_decode_n6();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
